stat_poller: RTL and testbench
==============================

Name: stat_poller

Overview:
- Read-side companion to the per-flow statistics accumulator.
- On a start pulse, it sweeps flows 0..FLOW_CNT-1 and issues one read-and-clear strobe per flow on the accumulator's read port.
- It collects each returned byte count and emits one record per flow on a valid/ready stream toward the host/export logic.
- It also keeps a running sweep total and flags any flow whose read response times out.

Parameters:
- A_WIDTH, 10: flow-number width; must match the accumulator.
- D_WIDTH, 32: per-flow counter width; must match the accumulator.
- FLOW_CNT, 2**A_WIDTH: number of flows swept, 1..2**A_WIDTH.
- TIMEOUT, 15: cycles to wait for rd_data_val_i before giving up on a flow, >=2.
- TOT_WIDTH, 48: sweep-total width, >= D_WIDTH.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  1-cycle pulse; begins a sweep when idle.
- skip_zero_i  in  1  suppress records with zero count; sampled at start.
- busy_o  out  1  high from the cycle after start is accepted until done_o.
- done_o  out  1  1-cycle pulse at sweep end.
- tot_bytes_o  out  TOT_WIDTH  saturating sum of all counts in the last sweep; stable while idle.
- timeout_o  out  1  sticky; set if any flow timed out this sweep; cleared at start.
- rd_stb_o  out  1  read-and-clear strobe to the accumulator.
- rd_flow_num_o  out  A_WIDTH  flow being read.
- rd_data_i  in  D_WIDTH  accumulator read data.
- rd_data_val_i  in  1  accumulator read-data valid.
- rec_valid_o  out  1  record valid.
- rec_ready_i  in  1  record consumer ready.
- rec_flow_o  out  A_WIDTH  record flow number.
- rec_bytes_o  out  D_WIDTH  record byte count.
- rec_err_o  out  1  record produced by timeout; rec_bytes_o=0.
- rec_last_o  out  1  record is for flow FLOW_CNT-1.

Behaviour:
- Reset values (async, while rst_i=0): FSM=IDLE, all outputs 0, flow counter 0, timer 0.
- Reset mid-sweep aborts immediately with no done_o. The accumulator's read-and-clear already issued is not undone.
- All outputs are registered.

FSM states:
- IDLE:
  - start_i=1 -> clear tot_bytes_o and timeout_o, latch skip_zero_i, flow=0, busy_o=1, go to REQ.
  - start_i while busy is ignored, with no queuing.
- REQ:
  - rd_stb_o=1 for exactly one cycle with rd_flow_num_o=flow, then go to WAIT with timer=0.
  - rd_stb_o is never high in any other state.
- WAIT:
  - The first cycle with rd_data_val_i=1 captures rd_data_i and goes to OUT.
  - Otherwise the timer increments. When it reaches TIMEOUT-1 with no valid, capture 0, set err, set timeout_o, go to OUT.
  - rd_data_val_i in any state other than WAIT is ignored.
  - Nominal path: the accumulator returns data the cycle after rd_stb_o, so REQ->WAIT->OUT takes 2 cycles.
- OUT:
  - Add the captured count to tot_bytes_o, saturating at all-ones of TOT_WIDTH.
  - Skip rule: if latched skip_zero=1, count==0, err=0 and flow != FLOW_CNT-1, emit no record; advance flow and go to REQ next cycle.
  - Otherwise rec_valid_o=1 with rec_flow_o/rec_bytes_o/rec_err_o/rec_last_o held stable until rec_ready_i=1. Valid is never dropped without a handshake.
  - On handshake: if flow==FLOW_CNT-1 go to DONE; else flow+1 and go to REQ.
  - The last flow always emits a record, even when zero and skip is active.
- DONE: done_o=1 for one cycle, busy_o=0, go to IDLE. tot_bytes_o and timeout_o hold until the next start.
- Throughput: with rec_ready_i=1 and immediate valid, one record per 3 cycles (REQ, WAIT, OUT).
- FLOW_CNT=1: a single request; rec_last_o=1 on the first record.

Test Plan:
- FLOW_CNT=4; accumulator model holds {10,0,7,3}; start, ready=1, skip=0 -> 4 records (0,10),(1,0),(2,7),(3,3,last); tot_bytes_o=20; done_o one pulse; model counters all 0 afterward.
- Same contents with skip_zero_i=1 -> records for flows 0,2,3 only; flow 1 strobed but not emitted; tot=20.
- Hold rec_ready_i=0 for 5 cycles on flow 2 -> rec_valid_o and payload stable all 5 cycles; no rd_stb_o for flow 3 until the handshake.
- Model never answers flow 1, TIMEOUT=15 -> after 15 WAIT cycles, record (1,0,err=1); timeout_o=1 through done; the next start clears it.
- Counts 0xFFFFFFFF on all 4 flows, TOT_WIDTH=33 -> tot saturates at 0x1_FFFFFFFF.
- Assert rst_i=0 while in WAIT for flow 2 -> all outputs 0 at once; no done_o; a new start after release begins at flow 0.

Source files
------------

// File: rtl/stat_poller.sv
// Read-side sweeper for the per-flow statistics accumulator: read-and-clears each flow in turn
// and streams one record per flow, keeping a saturating sweep total and a sticky timeout flag.
module stat_poller #(
  parameter int unsigned A_WIDTH   = 10,
  parameter int unsigned D_WIDTH   = 32,
  parameter int unsigned FLOW_CNT  = 2**A_WIDTH,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned TOT_WIDTH = 48
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 skip_zero_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [TOT_WIDTH-1:0] tot_bytes_o,
  output logic                 timeout_o,
  output logic                 rd_stb_o,
  output logic [A_WIDTH-1:0]   rd_flow_num_o,
  input  logic [D_WIDTH-1:0]   rd_data_i,
  input  logic                 rd_data_val_i,
  output logic                 rec_valid_o,
  input  logic                 rec_ready_i,
  output logic [A_WIDTH-1:0]   rec_flow_o,
  output logic [D_WIDTH-1:0]   rec_bytes_o,
  output logic                 rec_err_o,
  output logic                 rec_last_o
);

  localparam int unsigned        TmrWidth = $clog2(TIMEOUT);
  localparam int unsigned        SumWidth = TOT_WIDTH + 1;
  localparam logic [A_WIDTH-1:0] LastFlow = A_WIDTH'(FLOW_CNT - 1);
  localparam logic [TmrWidth-1:0] TmrMax  = TmrWidth'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StOut, StDone} state_e;

  state_e                state_q, state_d;
  logic [A_WIDTH-1:0]    flow_q, flow_d;
  logic [TmrWidth-1:0]   timer_q, timer_d;
  logic                  skip_q, skip_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [TOT_WIDTH-1:0]  tot_q, tot_d;
  logic                  timeout_q, timeout_d;
  logic                  rd_stb_q, rd_stb_d;
  logic [A_WIDTH-1:0]    rd_flow_q, rd_flow_d;
  logic                  rec_valid_q, rec_valid_d;
  logic [A_WIDTH-1:0]    rec_flow_q, rec_flow_d;
  logic [D_WIDTH-1:0]    rec_bytes_q, rec_bytes_d;
  logic                  rec_err_q, rec_err_d;
  logic                  rec_last_q, rec_last_d;

  logic                  cap_now;
  logic                  cap_err;
  logic [D_WIDTH-1:0]    cap;
  logic [SumWidth-1:0]   sum;

  always_comb begin
    state_d     = state_q;
    flow_d      = flow_q;
    timer_d     = timer_q;
    skip_d      = skip_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tot_d       = tot_q;
    timeout_d   = timeout_q;
    rd_stb_d    = 1'b0;
    rd_flow_d   = rd_flow_q;
    rec_valid_d = rec_valid_q;
    rec_flow_d  = rec_flow_q;
    rec_bytes_d = rec_bytes_q;
    rec_err_d   = rec_err_q;
    rec_last_d  = rec_last_q;
    cap_now     = 1'b0;
    cap_err     = 1'b0;
    cap         = rd_data_i;
    sum         = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          tot_d     = '0;
          timeout_d = 1'b0;
          skip_d    = skip_zero_i;
          flow_d    = '0;
          busy_d    = 1'b1;
          rd_stb_d  = 1'b1;
          rd_flow_d = '0;
          state_d   = StReq;
        end
      end
      StReq: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        if (rd_data_val_i) begin
          cap_now = 1'b1;
        end else if (timer_q == TmrMax) begin
          cap_now   = 1'b1;
          cap       = '0;
          cap_err   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TmrWidth'(1);
        end
      end
      StOut: begin
        // A skipped flow sits here one cycle with valid low; otherwise wait for the handshake.
        if (!rec_valid_q || rec_ready_i) begin
          rec_valid_d = 1'b0;
          if (flow_q == LastFlow) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            flow_d    = flow_q + A_WIDTH'(1);
            rd_stb_d  = 1'b1;
            rd_flow_d = flow_q + A_WIDTH'(1);
            state_d   = StReq;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (cap_now) begin
      sum         = {1'b0, tot_q} + SumWidth'(cap);
      tot_d       = sum[TOT_WIDTH] ? '1 : sum[TOT_WIDTH-1:0];
      rec_flow_d  = flow_q;
      rec_bytes_d = cap;
      rec_err_d   = cap_err;
      rec_last_d  = (flow_q == LastFlow);
      rec_valid_d = !(skip_q && (cap == '0) && !cap_err && (flow_q != LastFlow));
      state_d     = StOut;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      flow_q      <= '0;
      timer_q     <= '0;
      skip_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tot_q       <= '0;
      timeout_q   <= 1'b0;
      rd_stb_q    <= 1'b0;
      rd_flow_q   <= '0;
      rec_valid_q <= 1'b0;
      rec_flow_q  <= '0;
      rec_bytes_q <= '0;
      rec_err_q   <= 1'b0;
      rec_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flow_q      <= flow_d;
      timer_q     <= timer_d;
      skip_q      <= skip_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tot_q       <= tot_d;
      timeout_q   <= timeout_d;
      rd_stb_q    <= rd_stb_d;
      rd_flow_q   <= rd_flow_d;
      rec_valid_q <= rec_valid_d;
      rec_flow_q  <= rec_flow_d;
      rec_bytes_q <= rec_bytes_d;
      rec_err_q   <= rec_err_d;
      rec_last_q  <= rec_last_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign tot_bytes_o   = tot_q;
  assign timeout_o     = timeout_q;
  assign rd_stb_o      = rd_stb_q;
  assign rd_flow_num_o = rd_flow_q;
  assign rec_valid_o   = rec_valid_q;
  assign rec_flow_o    = rec_flow_q;
  assign rec_bytes_o   = rec_bytes_q;
  assign rec_err_o     = rec_err_q;
  assign rec_last_o    = rec_last_q;

endmodule

// File: tb/tb_stat_poller.sv
// Bench for stat_poller: 4 flows, 33-bit total; an accumulator model answers strobes and a
// sweep-level model predicts the record list, total and timeout flag.
module tb_stat_poller;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned FC = 4;
  localparam int unsigned TO = 15;
  localparam int unsigned TW = 33;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic          skip_zero_i = 1'b0;
  logic          busy_o, done_o, timeout_o, rd_stb_o;
  logic [TW-1:0] tot_bytes_o;
  logic [AW-1:0] rd_flow_num_o;
  logic [DW-1:0] rd_data_i = '0;
  logic          rd_data_val_i = 1'b0;
  logic          rec_valid_o;
  logic          rec_ready_i = 1'b1;
  logic [AW-1:0] rec_flow_o;
  logic [DW-1:0] rec_bytes_o;
  logic          rec_err_o, rec_last_o;

  stat_poller #(
    .A_WIDTH(AW), .D_WIDTH(DW), .FLOW_CNT(FC), .TIMEOUT(TO), .TOT_WIDTH(TW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .skip_zero_i(skip_zero_i),
    .busy_o(busy_o), .done_o(done_o), .tot_bytes_o(tot_bytes_o), .timeout_o(timeout_o),
    .rd_stb_o(rd_stb_o), .rd_flow_num_o(rd_flow_num_o), .rd_data_i(rd_data_i),
    .rd_data_val_i(rd_data_val_i), .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
    .rec_flow_o(rec_flow_o), .rec_bytes_o(rec_bytes_o), .rec_err_o(rec_err_o),
    .rec_last_o(rec_last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  flow;
    logic [31:0] bytes;
    logic        err;
    logic        last;
  } rec_t;

  typedef struct packed {
    logic [3:0][31:0] cnt;
    logic             skip;
    logic [3:0]       noans;
    logic [32:0]      tot;
    logic             to;
    logic [2:0]       nrec;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] acc [4];
  bit          noans [4];
  int          stb_cyc [4];
  int          exp_lat [4];
  rec_t        got_q [$];
  int          stb_q [$];
  int          cyc = 0;
  bit          pend = 0;
  int          pcnt = 0;
  logic [31:0] pdata = '0;
  bit          held = 0;
  rec_t        hrec;
  int          hold_left = 0;
  int          hold_seen = 0;
  logic [1:0]  hold_flow = 2'd2;
  bit          rand_mode = 0;
  bit          rand_ready = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_ctl"}, 64'({busy_o, done_o, timeout_o, rd_stb_o, rec_valid_o, rec_err_o,
                             rec_last_o, rd_flow_num_o, rec_flow_o}), 64'(0));
    check({nm, "_tot"}, 64'(tot_bytes_o), 64'(0));
    check({nm, "_bytes"}, 64'(rec_bytes_o), 64'(0));
  endtask

  // Consumer, monitor and accumulator model, all acting mid-cycle.
  always @(negedge clk_i) begin
    rec_t cur;
    int   f;
    int   d;
    cyc++;
    if (!rst_i) begin
      pend = 0;
      held = 0;
      rd_data_val_i = 1'b0;
    end else begin
      if (hold_left > 0 && rec_valid_o && rec_flow_o == hold_flow) begin
        rec_ready_i = 1'b0;
        hold_left--;
      end else if (rand_ready) begin
        rec_ready_i = ($urandom_range(0, 2) != 0);
      end else begin
        rec_ready_i = 1'b1;
      end
      cur = '{flow: rec_flow_o, bytes: rec_bytes_o, err: rec_err_o, last: rec_last_o};
      if (rec_valid_o) begin
        if (held) check("rec_stable", 64'(cur), 64'(hrec));
        else check("rec_latency", 64'(cyc - stb_cyc[rec_flow_o]), 64'(exp_lat[rec_flow_o]));
        if (rec_ready_i) begin
          got_q.push_back(cur);
          held = 0;
        end else begin
          held = 1;
          hrec = cur;
          if (rec_flow_o == hold_flow) hold_seen++;
        end
      end else if (held) begin
        check("rec_valid_held", 64'(rec_valid_o), 64'(1));
        held = 0;
      end
      if (rd_stb_o) check("stb_not_during_rec", 64'(rec_valid_o), 64'(0));

      rd_data_val_i = 1'b0;
      rd_data_i = $urandom;
      if (pend) begin
        pcnt--;
        if (pcnt == 0) begin
          rd_data_val_i = 1'b1;
          rd_data_i = pdata;
          pend = 0;
        end
      end
      if (rd_stb_o) begin
        f = int'(rd_flow_num_o);
        stb_q.push_back(f);
        stb_cyc[f] = cyc;
        d = rand_mode ? int'($urandom_range(1, 3)) : 1;
        if (!noans[f]) begin
          pend = 1;
          pcnt = d;
          pdata = acc[f];
          exp_lat[f] = d + 1;
        end else begin
          exp_lat[f] = int'(TO) + 1;
        end
        acc[f] = '0;
      end
    end
  end

  task automatic run_sweep(input bit skip, input bit use_tab, input vec_t v);
    rec_t        exp_q [$];
    longint      sum;
    logic [32:0] etot;
    bit          eto;
    int          n;
    int          m;
    sum = 0;
    eto = 0;
    for (int f = 0; f < 4; f++) begin
      logic [31:0] b;
      b = noans[f] ? 32'd0 : acc[f];
      sum += longint'(b);
      eto |= noans[f];
      if (!(skip && b == 0 && !noans[f] && f != 3))
        exp_q.push_back('{flow: 2'(f), bytes: b, err: noans[f], last: (f == 3)});
    end
    etot = (sum > 64'h1_FFFF_FFFF) ? 33'h1_FFFF_FFFF : 33'(sum);
    got_q.delete();
    stb_q.delete();

    @(negedge clk_i);
    start_i = 1'b1;
    skip_zero_i = skip;
    @(negedge clk_i);
    start_i = 1'b0;
    skip_zero_i = 1'($urandom);
    check("start_busy", 64'(busy_o), 64'(1));
    check("start_stb", 64'({rd_stb_o, rd_flow_num_o}), 64'({1'b1, 2'd0}));
    check("start_clears", 64'({timeout_o, tot_bytes_o}), 64'(0));

    n = 0;
    while (!done_o && n < 600) begin
      @(negedge clk_i);
      n++;
      if (!done_o && rand_mode) start_i = ($urandom_range(0, 7) == 0);
    end
    start_i = 1'b0;
    check("done_seen", 64'(done_o), 64'(1));
    check("busy_at_done", 64'(busy_o), 64'(0));
    check("timeout_at_done", 64'(timeout_o), 64'(eto));
    @(negedge clk_i);
    check("done_one_pulse", 64'({done_o, busy_o}), 64'(0));
    check("tot_model", 64'(tot_bytes_o), 64'(etot));
    check("timeout_hold", 64'(timeout_o), 64'(eto));
    if (use_tab) begin
      check("tot_table", 64'(tot_bytes_o), 64'(v.tot));
      check("timeout_table", 64'(timeout_o), 64'(v.to));
      check("nrec_table", 64'(got_q.size()), 64'(v.nrec));
    end
    check("nrec_model", 64'(got_q.size()), 64'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check("rec_model", 64'(got_q[i]), 64'(exp_q[i]));
    check("nstb", 64'(stb_q.size()), 64'(4));
    for (int i = 0; i < stb_q.size() && i < 4; i++) check("stb_order", 64'(stb_q[i]), 64'(i));
    for (int f = 0; f < 4; f++) check("acc_cleared", 64'(acc[f]), 64'(0));
  endtask

  task automatic load(input vec_t v);
    for (int f = 0; f < 4; f++) begin
      acc[f] = v.cnt[f];
      noans[f] = v.noans[f];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab [5];
    vec_t v;
    int   n;
    bit   done_seen;

    tab[0] = '{cnt: {32'd3, 32'd7, 32'd0, 32'd10}, skip: 1'b0, noans: 4'b0000,
               tot: 33'd20, to: 1'b0, nrec: 3'd4};
    tab[1] = '{cnt: {32'd3, 32'd7, 32'd0, 32'd10}, skip: 1'b1, noans: 4'b0000,
               tot: 33'd20, to: 1'b0, nrec: 3'd3};
    tab[2] = '{cnt: {32'd3, 32'd7, 32'd0, 32'd10}, skip: 1'b0, noans: 4'b0010,
               tot: 33'd20, to: 1'b1, nrec: 3'd4};
    tab[3] = '{cnt: {4{32'hFFFF_FFFF}}, skip: 1'b0, noans: 4'b0000,
               tot: 33'h1_FFFF_FFFF, to: 1'b0, nrec: 3'd4};
    tab[4] = '{cnt: {4{32'd0}}, skip: 1'b1, noans: 4'b0000,
               tot: 33'd0, to: 1'b0, nrec: 3'd1};

    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle_no_busy", 64'({busy_o, rd_stb_o}), 64'(0));

    for (int i = 0; i < 5; i++) begin
      load(tab[i]);
      run_sweep(tab[i].skip, 1'b1, tab[i]);
    end

    // Stall the consumer for 5 cycles on flow 2.
    load(tab[0]);
    hold_seen = 0;
    hold_flow = 2'd2;
    hold_left = 5;
    run_sweep(1'b0, 1'b1, tab[0]);
    check("hold_cycles", 64'(hold_seen), 64'(5));

    rand_mode = 1;
    rand_ready = 1;
    for (int s = 0; s < 10; s++) begin
      for (int f = 0; f < 4; f++) begin
        v.cnt[f] = ($urandom_range(0, 2) == 0) ? 32'd0 :
                   ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(1, 5000));
        v.noans[f] = ($urandom_range(0, 7) == 0);
      end
      load(v);
      run_sweep(1'($urandom), 1'b0, v);
    end
    rand_mode = 0;
    rand_ready = 0;

    // Reset while waiting on flow 2, then confirm a clean restart from flow 0.
    load(tab[0]);
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 0;
    while (!(rd_stb_o && rd_flow_num_o == 2'd2) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("reach_flow2", 64'({rd_stb_o, rd_flow_num_o}), 64'({1'b1, 2'd2}));
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1 check_all_zero("reset_mid");
    done_seen = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (done_o) done_seen = 1;
    end
    rst_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      if (done_o || busy_o) done_seen = 1;
    end
    check("no_done_after_reset", 64'(done_seen), 64'(0));
    run_sweep(1'b0, 1'b0, tab[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
